// File: rtl/osc_pkg.sv
// osc_pkg: shared constants for the oscillator output path
// Full-scale sample limits, unity-gain helper and waveform shape encoding.
package osc_pkg;
  localparam logic signed [31:0] FS_POS = 32'sh3FFF_FFFF;
  localparam logic signed [31:0] FS_NEG = 32'shC000_0000;
  localparam logic SHAPE_SINE = 1'b0;
  localparam logic SHAPE_SQUARE = 1'b1;
  localparam int GAIN_W_DEF = 16;
  localparam int unsigned UNITY_GAIN_DEF = 32'd1 << (GAIN_W_DEF - 1);
  function automatic int unsigned unity_gain(input int gain_w);
    return 32'd1 << (gain_w - 1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with registered storage and flush
// Ports: Fg_clk/Resetn (async active-low), flush empties the FIFO with priority,
// push/din write (dropped when full unless popping), pop/dout read head,
// full/empty status. dout reads 0 while empty.
module sync_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic         Fg_clk,
  input  logic         Resetn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_d, wr_q, rd_d, rd_q;
  logic [AW:0] cnt_d, cnt_q;
  logic wr, rd;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rd_q];
  // a push into a full FIFO only lands when the head leaves in the same cycle
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      if (wr) mem_d[wr_q] = din;
      wr_d = wr ? wr_q + AW'(1) : wr_q;
      rd_d = rd ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge Fg_clk or negedge Resetn)
    if (!Resetn) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/osc_dac_formatter.sv
// osc_dac_formatter: gain/offset/saturate oscillator samples into buffered DAC codes
// Ports: Fg_clk/Resetn (async active-low); s_valid/s_data oscillator samples;
// flush clears pipeline and FIFO; shape selects sine or square; gain (Q1.GAIN_W-1)
// and offset set amplitude and DC level; clr_stat clears clip_cnt/ovf;
// dac_valid/dac_code/dac_ready is the FIFO head handshake to the serializer.
module osc_dac_formatter
  import osc_pkg::*;
#(
  parameter int DAC_W = 12,
  parameter int GAIN_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               Fg_clk,
  input  logic               Resetn,
  input  logic               s_valid,
  input  logic signed [31:0] s_data,
  input  logic               flush,
  input  logic               shape,
  input  logic [GAIN_W-1:0]  gain,
  input  logic signed [31:0] offset,
  input  logic               clr_stat,
  output logic               dac_valid,
  output logic [DAC_W-1:0]   dac_code,
  input  logic               dac_ready,
  output logic [15:0]        clip_cnt,
  output logic               ovf
);
  localparam int PW = 33 + GAIN_W;
  localparam int YW = PW + 1;
  logic signed [31:0] x;
  logic signed [PW-1:0] prod;
  logic signed [YW-1:0] y;
  logic s1_v_d, s1_v_q, s2_v_d, s2_v_q, s2_clip_d, s2_clip_q, ovf_d, ovf_q, full, empty;
  logic signed [PW-1:0] s1_d, s1_q;
  logic [DAC_W-1:0] s2_code_d, s2_code_q;
  logic [15:0] clip_cnt_d, clip_cnt_q, cnt_base;
  always_comb begin
    x = shape == SHAPE_SQUARE ? (s_data[31] ? FS_NEG : FS_POS) : s_data;
    prod = PW'(x) * PW'($signed({1'b0, gain}));
    s1_d = prod >>> (GAIN_W - 1);
    s1_v_d = s_valid & ~flush;
    y = YW'(s1_q) + YW'(offset);
    s2_v_d = s1_v_q & ~flush;
    s2_clip_d = (y > YW'(FS_POS)) || (y < YW'(FS_NEG));
    // in range, bit 30 is the inverted sign of the offset-binary code
    s2_code_d = y > YW'(FS_POS) ? '1 : y < YW'(FS_NEG) ? '0 : {~y[30], y[29:31-DAC_W]};
    // clear first so a same-cycle event still registers
    cnt_base = clr_stat ? '0 : clip_cnt_q;
    clip_cnt_d = (s2_v_q & s2_clip_q & ~flush & ~&cnt_base) ? cnt_base + 16'd1 : cnt_base;
    ovf_d = (ovf_q & ~clr_stat) | (s2_v_q & ~flush & full & ~dac_ready);
  end
  always_ff @(posedge Fg_clk or negedge Resetn)
    if (!Resetn) begin
      s1_v_q <= 1'b0;
      s1_q <= '0;
      s2_v_q <= 1'b0;
      s2_clip_q <= 1'b0;
      s2_code_q <= '0;
      clip_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_q <= s1_d;
      s2_v_q <= s2_v_d;
      s2_clip_q <= s2_clip_d;
      s2_code_q <= s2_code_d;
      clip_cnt_q <= clip_cnt_d;
      ovf_q <= ovf_d;
    end
  sync_fifo #(.W(DAC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Fg_clk(Fg_clk),
    .Resetn(Resetn),
    .flush (flush),
    .push  (s2_v_q),
    .din   (s2_code_q),
    .pop   (dac_ready),
    .dout  (dac_code),
    .full  (full),
    .empty (empty)
  );
  assign dac_valid = ~empty;
  assign clip_cnt = clip_cnt_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_osc_dac_formatter.sv
// tb_osc_dac_formatter: directed and randomized checks against an arithmetic reference model
module tb_osc_dac_formatter;
  import osc_pkg::*;
  localparam int DAC_W = 12;
  localparam int GAIN_W = 16;
  localparam int DEPTH = 4;
  localparam longint FSP = 64'sd1073741823;
  localparam longint FSN = -64'sd1073741824;
  logic Fg_clk = 0, Resetn = 0, s_valid = 0, flush = 0, shape = 0, clr_stat = 0, dac_ready = 0;
  logic signed [31:0] s_data = 0, offset = 0;
  logic [GAIN_W-1:0] gain = 0;
  logic dac_valid, ovf;
  logic [DAC_W-1:0] dac_code;
  logic [15:0] clip_cnt;
  int checks = 0, passed = 0;
  bit m1_v, m2_v, m2_clip, movf;
  longint m1_p;
  int mcnt;
  logic [DAC_W-1:0] m2_code;
  logic [DAC_W-1:0] mq[$];

  osc_dac_formatter #(.DAC_W(DAC_W), .GAIN_W(GAIN_W), .FIFO_DEPTH(DEPTH)) dut (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .s_valid(s_valid), .s_data(s_data), .flush(flush),
    .shape(shape), .gain(gain), .offset(offset), .clr_stat(clr_stat), .dac_valid(dac_valid),
    .dac_code(dac_code), .dac_ready(dac_ready), .clip_cnt(clip_cnt), .ovf(ovf)
  );

  always #5 Fg_clk = ~Fg_clk;

  task automatic model_reset();
    m1_v = 0; m2_v = 0; m2_clip = 0; m1_p = 0; m2_code = 0; mcnt = 0; movf = 0;
    mq.delete();
  endtask

  // one clock edge of the reference behaviour, using the inputs present at the edge
  task automatic model_step();
    bit full, pop, push, drop;
    longint x, y, yc;
    full = mq.size() == DEPTH;
    pop = !flush && mq.size() > 0 && dac_ready;
    push = m2_v && !flush;
    drop = push && full && !pop;
    if (clr_stat) begin mcnt = 0; movf = 0; end
    if (push && m2_clip) mcnt = mcnt == 65535 ? 65535 : mcnt + 1;
    if (drop) movf = 1;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(m2_code);
    end
    if (flush) m2_v = 0;
    else begin
      y = m1_p + longint'(offset);
      m2_v = m1_v;
      m2_clip = y > FSP || y < FSN;
      yc = y > FSP ? FSP : y < FSN ? FSN : y;
      m2_code = DAC_W'((yc - FSN) >> (31 - DAC_W));
    end
    m1_v = s_valid && !flush;
    x = shape ? (s_data[31] ? FSN : FSP) : longint'(s_data);
    m1_p = (x * longint'(gain)) >>> (GAIN_W - 1);
  endtask

  task automatic cycle(input bit sv, input logic [31:0] sd, input bit rdy, input bit fl, input bit clr);
    s_valid = sv; s_data = sd; dac_ready = rdy; flush = fl; clr_stat = clr;
    @(posedge Fg_clk);
    model_step();
    #1;
  endtask

  function automatic logic [DAC_W-1:0] unity_code(input logic [31:0] sd);
    longint v;
    v = longint'($signed(sd));
    v = v > FSP ? FSP : v < FSN ? FSN : v;
    return DAC_W'((v - FSN) >> (31 - DAC_W));
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (dac_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dac_valid); else passed++;
    checks++; if (dac_code !== '0) $display("FAIL reset_code: got %h want 0", dac_code); else passed++;
    checks++; if (clip_cnt !== 16'd0) $display("FAIL reset_clip: got %h want 0", clip_cnt); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    model_reset();
    @(negedge Fg_clk);
    Resetn = 1;
  endtask

  task automatic test_sine();
    logic [31:0] smp[3] = '{32'h0, 32'h3FFF_FFFF, 32'hC000_0000};
    logic [DAC_W-1:0] want[3] = '{12'h800, 12'hFFF, 12'h000};
    gain = 16'(unity_gain(GAIN_W)); offset = 0; shape = SHAPE_SINE;
    for (int i = 0; i < 3; i++) begin
      cycle(1, smp[i], 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      checks++; if (dac_valid !== 1'b0) $display("FAIL sine_early%0d: got valid %b want 0", i, dac_valid); else passed++;
      cycle(0, 0, 1, 0, 0);
      checks++; if (dac_valid !== 1'b1 || dac_code !== want[i])
        $display("FAIL sine_code%0d: got %b/%h want 1/%h", i, dac_valid, dac_code, want[i]); else passed++;
      cycle(0, 0, 1, 0, 0);
    end
    checks++; if (clip_cnt !== 16'd0) $display("FAIL sine_clip: got %0d want 0", clip_cnt); else passed++;
  endtask

  task automatic test_clip();
    cycle(1, 32'h4000_0000, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (dac_code !== 12'hFFF) $display("FAIL clip_hi: got %h want fff", dac_code); else passed++;
    offset = 32'h7FFF_FFFF;
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (dac_code !== 12'hFFF) $display("FAIL clip_off: got %h want fff", dac_code); else passed++;
    checks++; if (clip_cnt !== 16'd2) $display("FAIL clip_cnt: got %0d want 2", clip_cnt); else passed++;
    offset = 0;
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 0);
    checks++; if (clip_cnt !== 16'd0) $display("FAIL clip_clr: got %0d want 0", clip_cnt); else passed++;
  endtask

  task automatic test_gain_square();
    gain = 16'h4000;
    cycle(1, 32'h2000_0000, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (dac_code !== 12'hA00) $display("FAIL half_gain: got %h want a00", dac_code); else passed++;
    shape = SHAPE_SQUARE; gain = 16'h8000;
    cycle(1, -32'sd5, 1, 0, 0);
    cycle(1, 32'sd5, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (dac_code !== 12'h000) $display("FAIL square_neg: got %h want 000", dac_code); else passed++;
    cycle(0, 0, 1, 0, 0);
    checks++; if (dac_code !== 12'hFFF) $display("FAIL square_pos: got %h want fff", dac_code); else passed++;
    checks++; if (clip_cnt !== 16'd0) $display("FAIL square_clip: got %0d want 0", clip_cnt); else passed++;
    shape = SHAPE_SINE;
    cycle(0, 0, 1, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] smp[6];
    for (int i = 0; i < 6; i++) smp[i] = $urandom_range(0, 32'h7FFF_FFFF) - 32'h4000_0000;
    for (int i = 0; i < 6; i++) begin
      cycle(1, smp[i], 0, 0, 0);
      if (i >= 3) begin
        checks++; if (dac_code !== unity_code(smp[0]))
          $display("FAIL bp_frozen%0d: got %h want %h", i, dac_code, unity_code(smp[0])); else passed++;
      end
    end
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf: got %b want 1", ovf); else passed++;
    checks++; if (mq.size() != 4) $display("FAIL bp_model_depth: got %0d want 4", mq.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dac_valid !== 1'b1 || dac_code !== unity_code(smp[i]))
        $display("FAIL bp_order%0d: got %b/%h want 1/%h", i, dac_valid, dac_code, unity_code(smp[i])); else passed++;
      cycle(0, 0, 1, 0, 0);
    end
    checks++; if (dac_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", dac_valid); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] smp[5];
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) smp[i] = 32'(i) << 26;
    for (int i = 0; i < 5; i++) cycle(1, smp[i], 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++; if (ovf !== 1'b0) $display("FAIL fpp_ovf: got %b want 0", ovf); else passed++;
    checks++; if (dac_code !== unity_code(smp[1])) $display("FAIL fpp_head: got %h want %h", dac_code, unity_code(smp[1])); else passed++;
    for (int i = 1; i < 5; i++) begin
      checks++; if (dac_valid !== 1'b1 || dac_code !== unity_code(smp[i]))
        $display("FAIL fpp_order%0d: got %b/%h want 1/%h", i, dac_valid, dac_code, unity_code(smp[i])); else passed++;
      cycle(0, 0, 1, 0, 0);
    end
    checks++; if (dac_valid !== 1'b0) $display("FAIL fpp_empty: got %b want 0", dac_valid); else passed++;
    cycle(1, 32'h1234_5678, 0, 0, 0);
    cycle(1, 32'h0765_4321, 0, 0, 0);
    cycle(1, 32'h1111_1111, 0, 0, 0);
    cycle(1, 32'h2222_2222, 0, 1, 0);
    checks++; if (dac_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", dac_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0);
      checks++; if (dac_valid !== 1'b0) $display("FAIL flush_stale%0d: got %b want 0", i, dac_valid); else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) gain = 16'($urandom);
      if ($urandom_range(0, 15) == 0) offset = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 32'h1000_0000)) - 32'h0800_0000;
      if ($urandom_range(0, 31) == 0) shape = ~shape;
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
      checks++; if (dac_valid !== (mq.size() > 0)) $display("FAIL rnd_valid%0d: got %b want %b", i, dac_valid, mq.size() > 0); else passed++;
      if (mq.size() > 0) begin
        checks++; if (dac_code !== mq[0]) $display("FAIL rnd_code%0d: got %h want %h", i, dac_code, mq[0]); else passed++;
      end
      checks++; if (clip_cnt !== 16'(mcnt)) $display("FAIL rnd_clip%0d: got %0d want %0d", i, clip_cnt, mcnt); else passed++;
      checks++; if (ovf !== movf) $display("FAIL rnd_ovf%0d: got %b want %b", i, ovf, movf); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    gain = 16'h8000; offset = 0; shape = SHAPE_SINE;
    cycle(1, 32'h4000_0000, 0, 0, 0);
    cycle(1, 32'h1000_0000, 0, 0, 0);
    cycle(1, 32'h2000_0000, 0, 0, 0);
    #2 Resetn = 0;
    #1;
    checks++; if (dac_valid !== 1'b0 || dac_code !== '0 || clip_cnt !== 16'd0 || ovf !== 1'b0)
      $display("FAIL mid_reset: got %b/%h/%0d/%b want 0/0/0/0", dac_valid, dac_code, clip_cnt, ovf); else passed++;
    model_reset();
    @(negedge Fg_clk);
    Resetn = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0);
      checks++; if (dac_valid !== 1'b0 || clip_cnt !== 16'd0)
        $display("FAIL mid_stale%0d: got %b/%0d want 0/0", i, dac_valid, clip_cnt); else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sine();
    test_clip();
    test_gain_square();
    test_backpressure();
    test_full_push_pop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
